// File: rtl/hwpe_ctrl_package.sv
// Register map, acquire response codes and FSM encoding shared by
// the HWPE control offloader and its peripheral master port.
package hwpe_ctrl_package;

    localparam logic [31:0] REG_TRIGGER     = 32'h00;
    localparam logic [31:0] REG_ACQUIRE     = 32'h04;
    localparam logic [31:0] REG_FINISHED    = 32'h08;
    localparam logic [31:0] REG_STATUS      = 32'h0C;
    localparam logic [31:0] REG_RUNNING_JOB = 32'h10;

    localparam logic [31:0] ALL_CXT_BUSY          = 32'hFFFF_FFFF;
    localparam logic [31:0] ANOTHER_PE_OFFLOADING = 32'hFFFF_FFFE;

    typedef enum logic [3:0] {
        OFF_IDLE,
        OFF_ACQ,
        OFF_ACQ_W,
        OFF_BACKOFF,
        OFF_WR,
        OFF_WR_W,
        OFF_TRIG,
        OFF_TRIG_W,
        OFF_RESP
    } offload_state_t;

    function automatic logic is_busy_rsp(input logic [31:0] d);
        return (d == ALL_CXT_BUSY) || (d == ANOTHER_PE_OFFLOADING);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_periph_master_port.sv
// Single-outstanding req/gnt/r_valid initiator behind a simple
// command/response handshake.
module hwpe_ctrl_periph_master_port #(
    parameter int unsigned ID_WIDTH  = 16,
    parameter int unsigned MASTER_ID = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [31:0]         i_cmd_add,
    input  logic                i_cmd_wen,
    input  logic [31:0]         i_cmd_data,
    output logic                o_rsp_valid,
    output logic [31:0]         o_rsp_data,
    output logic                periph_req_o,
    input  logic                periph_gnt_i,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i
);

    logic        r_pend;
    logic        r_early;
    logic [31:0] r_rdata;
    logic        w_req;

    assign w_req       = i_cmd_valid & ~r_pend & ~r_early;
    assign o_cmd_ready = w_req & periph_gnt_i;

    assign periph_req_o  = w_req;
    assign periph_add_o  = w_req ? i_cmd_add : 32'h0;
    assign periph_wen_o  = w_req ? i_cmd_wen : 1'b1;
    assign periph_data_o = w_req ? i_cmd_data : 32'h0;
    assign periph_be_o   = 4'hF;
    assign periph_id_o   = ID_WIDTH'(MASTER_ID);

    // A response landing in the grant cycle is held one cycle so the
    // FSM, which only waits from the following cycle, still sees it.
    assign o_rsp_valid = r_early | (r_pend & periph_r_valid_i);
    assign o_rsp_data  = r_early ? r_rdata : periph_r_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend  <= 1'b0;
            r_early <= 1'b0;
            r_rdata <= 32'h0;
        end else if (clear_i) begin
            r_pend  <= 1'b0;
            r_early <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            if (o_cmd_ready && !periph_r_valid_i) begin
                r_pend <= 1'b1;
            end else if (r_pend && periph_r_valid_i) begin
                r_pend <= 1'b0;
            end
            if (o_cmd_ready && periph_r_valid_i) begin
                r_early <= 1'b1;
                r_rdata <= periph_r_data_i;
            end else begin
                r_early <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_offloader.sv
// Offloads one HWPE job: acquire a context, write IO registers,
// trigger, and return the job ID (or an abort) to the requester.
module hwpe_ctrl_offloader
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_IO_REGS      = 2,
    parameter int unsigned ID_WIDTH       = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [31:0] IO_OFFSET      = 32'h40,
    parameter int unsigned BACKOFF_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 0,
    parameter int unsigned MASTER_ID      = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [N_IO_REGS*32-1:0] job_data_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [7:0]             id_o,
    output logic                   abort_o,
    output logic                   busy_o,
    output logic                   periph_req_o,
    input  logic                   periph_gnt_i,
    output logic [31:0]            periph_add_o,
    output logic                   periph_wen_o,
    output logic [3:0]             periph_be_o,
    output logic [31:0]            periph_data_o,
    output logic [ID_WIDTH-1:0]    periph_id_o,
    input  logic                   periph_r_valid_i,
    input  logic [31:0]            periph_r_data_i,
    input  logic [ID_WIDTH-1:0]    periph_r_id_i
);

    localparam int unsigned IW = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IO_REGS - 1);
    localparam logic [15:0]   MAX_R    = 16'(MAX_RETRIES);
    localparam logic [15:0]   BO_LAST  = 16'(BACKOFF_CYCLES - 1);

    offload_state_t         r_state;
    offload_state_t         w_next;
    logic [N_IO_REGS*32-1:0] r_job;
    logic [IW-1:0]          r_idx;
    logic [15:0]            r_retry;
    logic [15:0]            r_bo;
    logic [7:0]             r_id;
    logic                   r_abort;

    logic        w_cmd_valid;
    logic        w_cmd_ready;
    logic [31:0] w_cmd_add;
    logic        w_cmd_wen;
    logic [31:0] w_cmd_data;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic [31:0] w_idx32;
    logic [15:0] w_retry_inc;
    logic        w_busy_rsp;
    logic        w_give_up;
    logic        w_unused;

    assign w_unused    = ^periph_r_id_i;
    assign w_idx32     = {{(32-IW){1'b0}}, r_idx};
    assign w_busy_rsp  = is_busy_rsp(w_rsp_data);
    assign w_retry_inc = (r_retry == 16'hFFFF) ? r_retry : r_retry + 16'd1;
    assign w_give_up   = (MAX_R != 16'd0) && (w_retry_inc == MAX_R);

    assign job_ready_o = (r_state == OFF_IDLE);
    assign busy_o      = (r_state != OFF_IDLE);
    assign id_valid_o  = (r_state == OFF_RESP);
    assign id_o        = r_id;
    assign abort_o     = r_abort;

    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_add   = 32'h0;
        w_cmd_wen   = 1'b1;
        w_cmd_data  = 32'h0;
        unique case (r_state)
            OFF_ACQ: begin
                w_cmd_valid = 1'b1;
                w_cmd_add   = BASE_ADDR + REG_ACQUIRE;
            end
            OFF_WR: begin
                w_cmd_valid = 1'b1;
                w_cmd_add   = BASE_ADDR + IO_OFFSET + (w_idx32 << 2);
                w_cmd_wen   = 1'b0;
                w_cmd_data  = r_job[w_idx32*32 +: 32];
            end
            OFF_TRIG: begin
                w_cmd_valid = 1'b1;
                w_cmd_add   = BASE_ADDR + REG_TRIGGER;
                w_cmd_wen   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            OFF_IDLE:    if (job_valid_i) w_next = OFF_ACQ;
            OFF_ACQ:     if (w_cmd_ready) w_next = OFF_ACQ_W;
            OFF_ACQ_W: begin
                if (w_rsp_valid) begin
                    if (!w_busy_rsp)    w_next = OFF_WR;
                    else if (w_give_up) w_next = OFF_RESP;
                    else                w_next = OFF_BACKOFF;
                end
            end
            OFF_BACKOFF: if (r_bo == BO_LAST) w_next = OFF_ACQ;
            OFF_WR:      if (w_cmd_ready) w_next = OFF_WR_W;
            OFF_WR_W: begin
                if (w_rsp_valid) begin
                    w_next = (r_idx == LAST_IDX) ? OFF_TRIG : OFF_WR;
                end
            end
            OFF_TRIG:    if (w_cmd_ready) w_next = OFF_TRIG_W;
            OFF_TRIG_W:  if (w_rsp_valid) w_next = OFF_RESP;
            OFF_RESP:    if (id_ready_i) w_next = OFF_IDLE;
            default:     w_next = OFF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= OFF_IDLE;
        end else if (clear_i) begin
            r_state <= OFF_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_job   <= '0;
            r_idx   <= '0;
            r_retry <= '0;
            r_bo    <= '0;
            r_id    <= '0;
            r_abort <= 1'b0;
        end else if (clear_i) begin
            r_job   <= '0;
            r_idx   <= '0;
            r_retry <= '0;
            r_bo    <= '0;
            r_id    <= '0;
            r_abort <= 1'b0;
        end else begin
            unique case (r_state)
                OFF_IDLE: begin
                    if (job_valid_i) begin
                        r_job   <= job_data_i;
                        r_retry <= '0;
                    end
                end
                OFF_ACQ_W: begin
                    if (w_rsp_valid && w_busy_rsp) begin
                        r_retry <= w_retry_inc;
                        r_bo    <= '0;
                        if (w_give_up) begin
                            r_id    <= '0;
                            r_abort <= 1'b1;
                        end
                    end else if (w_rsp_valid) begin
                        r_id    <= w_rsp_data[7:0];
                        r_abort <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                OFF_BACKOFF: r_bo <= r_bo + 16'd1;
                OFF_WR_W: begin
                    if (w_rsp_valid && r_idx != LAST_IDX) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    hwpe_ctrl_periph_master_port #(
        .ID_WIDTH  (ID_WIDTH),
        .MASTER_ID (MASTER_ID)
    ) i_port (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .i_cmd_valid      (w_cmd_valid),
        .o_cmd_ready      (w_cmd_ready),
        .i_cmd_add        (w_cmd_add),
        .i_cmd_wen        (w_cmd_wen),
        .i_cmd_data       (w_cmd_data),
        .o_rsp_valid      (w_rsp_valid),
        .o_rsp_data       (w_rsp_data),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (periph_gnt_i),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_valid_i (periph_r_valid_i),
        .periph_r_data_i  (periph_r_data_i)
    );

endmodule
